td_rf_reader: RTL and testbench

- Read-side controller for the time-domain register file.
- Accepts binary read requests (two 3-bit addresses) and launches a one-cycle `re` pulse with `ra`/`rb` addresses.
- Measures, in clock cycles, the arrival time of the returned `a`/`b` pulses and converts them back to binary codes. Sits between the digital request logic and the `re`/`ra*`/`rb*`/`a`/`b` pins of the register file.

---
 rtl/td_rf_pkg.sv | 17 +
 rtl/td_pulse_sync.sv | 27 ++
 rtl/td_rf_reader.sv | 148 ++++++++++++++
 tb/tb_td_rf_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/td_rf_pkg.sv
// Shared types and default sizing for the time-domain register file read controller.
package td_rf_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 200;

  typedef logic [2:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    MEASURE,
    RESP,
    GAP
  } rd_state_t;

endpackage

// File: rtl/td_pulse_sync.sv
// Multi-flop synchronizer for an asynchronous pulse input, followed by a
// rising-edge detector built on a registered copy of the synchronized level.
module td_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/td_rf_reader.sv
// Read-side controller: launches a read pulse, times the returned A/B pulses
// in clock cycles and reports the resulting delay codes with timeout flags.
module td_rf_reader
  import td_rf_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int GAP_CYC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_ra_i,
  input  logic [2:0]       req_rb_i,
  output logic             re_o,
  output logic [2:0]       ra_o,
  output logic [2:0]       rb_o,
  input  logic             a_i,
  input  logic             b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [CNT_W-1:0] rsp_a_o,
  output logic [CNT_W-1:0] rsp_b_o,
  output logic             rsp_a_to_o,
  output logic             rsp_b_to_o
);

  localparam int              GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CODE = CNT_W'(TIMEOUT);

  rd_state_t        r_state, w_next;
  logic [CNT_W-1:0] r_cnt, r_rspA, r_rspB;
  logic             r_gotA, r_gotB, r_toA, r_toB, r_ready;
  addr_t            r_ra, r_rb;
  logic [GW-1:0]    r_gap;
  logic             w_edgeA, w_edgeB, w_accept, w_capA, w_capB;

  td_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncA (
    .i_clk  (clk_i),
    .i_rst_n(rst_ni),
    .i_async(a_i),
    .o_edge (w_edgeA)
  );

  td_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncB (
    .i_clk  (clk_i),
    .i_rst_n(rst_ni),
    .i_async(b_i),
    .o_edge (w_edgeB)
  );

  assign w_accept = req_valid_i & r_ready;
  assign w_capA   = r_gotA | w_edgeA;
  assign w_capB   = r_gotB | w_edgeB;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = LAUNCH;
      LAUNCH:  w_next = MEASURE;
      MEASURE: if ((w_capA && w_capB) || (r_cnt == TO_CODE)) w_next = RESP;
      RESP:    if (rsp_ready_i) w_next = GAP;
      GAP:     if (r_gap == GW'(GAP_CYC - 1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Ready is registered so that every output reads 0 while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ready <= 1'b0;
      r_cnt   <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rspA  <= '0;
      r_rspB  <= '0;
      r_gotA  <= 1'b0;
      r_gotB  <= 1'b0;
      r_toA   <= 1'b0;
      r_toB   <= 1'b0;
      r_gap   <= '0;
    end else begin
      r_ready <= (w_next == IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ra  <= req_ra_i;
            r_rb  <= req_rb_i;
            r_cnt <= '0;
          end
        end
        LAUNCH: begin
          r_cnt  <= CNT_W'(1);
          r_gotA <= 1'b0;
          r_gotB <= 1'b0;
          r_toA  <= 1'b0;
          r_toB  <= 1'b0;
          r_rspA <= '0;
          r_rspB <= '0;
        end
        MEASURE: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
          if (!r_gotA && w_edgeA) begin
            r_gotA <= 1'b1;
            r_rspA <= r_cnt;
          end
          if (!r_gotB && w_edgeB) begin
            r_gotB <= 1'b1;
            r_rspB <= r_cnt;
          end
          // An edge landing in the final cycle still wins over the timeout.
          if (r_cnt == TO_CODE) begin
            if (!w_capA) begin
              r_rspA <= TO_CODE;
              r_toA  <= 1'b1;
            end
            if (!w_capB) begin
              r_rspB <= TO_CODE;
              r_toB  <= 1'b1;
            end
          end
        end
        RESP:    if (rsp_ready_i) r_gap <= '0;
        GAP:     r_gap <= r_gap + GW'(1);
        default: ;
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign re_o        = (r_state == LAUNCH);
  assign rsp_valid_o = (r_state == RESP);
  assign ra_o        = r_ra;
  assign rb_o        = r_rb;
  assign rsp_a_o     = r_rspA;
  assign rsp_b_o     = r_rspB;
  assign rsp_a_to_o  = r_toA;
  assign rsp_b_to_o  = r_toB;

endmodule

// File: tb/tb_td_rf_reader.sv
// Directed self-checking bench for td_rf_reader with hand-computed delay codes.
module tb_td_rf_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [2:0] req_ra_i = '0;
  logic [2:0] req_rb_i = '0;
  logic       re_o;
  logic [2:0] ra_o, rb_o;
  logic       a_i = 1'b0;
  logic       b_i = 1'b0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [7:0] rsp_a_o, rsp_b_o;
  logic       rsp_a_to_o, rsp_b_to_o;

  int checks = 0;
  int failures = 0;
  int aTog[$];
  int bTog[$];
  int rspCyc;
  int gapLen;
  int bad;

  always #5 clk = ~clk;

  td_rf_reader dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_ra_i   (req_ra_i),
    .req_rb_i   (req_rb_i),
    .re_o       (re_o),
    .ra_o       (ra_o),
    .rb_o       (rb_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_a_o    (rsp_a_o),
    .rsp_b_o    (rsp_b_o),
    .rsp_a_to_o (rsp_a_to_o),
    .rsp_b_to_o (rsp_b_to_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue one request, play the toggle queues against the measure cycle count
  // (LAUNCH cycle = 0) and stop at the first cycle showing a response.
  task automatic applyStimulus(input logic [2:0] ra, input logic [2:0] rb);
    int c;
    int reExtra;
    c = 0;
    reExtra = 0;
    checkOutput("req_ready_idle", req_ready_o, 1);
    req_ra_i = ra;
    req_rb_i = rb;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    checkOutput("re_launch", re_o, 1);
    checkOutput("ra_o", ra_o, ra);
    checkOutput("rb_o", rb_o, rb);
    while (!rsp_valid_o && c < 400) begin
      while (aTog.size() > 0 && aTog[0] == c) begin
        a_i = ~a_i;
        void'(aTog.pop_front());
      end
      while (bTog.size() > 0 && bTog[0] == c) begin
        b_i = ~b_i;
        void'(bTog.pop_front());
      end
      tick();
      c++;
      if (re_o) reExtra++;
    end
    checkOutput("re_single", reExtra, 0);
    checkOutput("rsp_arrive", rsp_valid_o, 1);
    rspCyc = c;
    aTog.delete();
    bTog.delete();
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checkOutput("valid_drop", rsp_valid_o, 0);
  endtask

  // Count cycles from the handshake cycle to ready, with short A/B pulses in GAP.
  task automatic waitIdle(output int cyc);
    int k;
    k = 1;
    while (!req_ready_o && k < 30) begin
      a_i = (k == 2);
      b_i = (k == 3);
      tick();
      k++;
    end
    a_i = 1'b0;
    b_i = 1'b0;
    cyc = k;
  endtask

  initial begin
    repeat (3) tick();
    checkOutput("reset_outputs", {req_ready_o, re_o, ra_o, rb_o, rsp_valid_o, rsp_a_o, rsp_b_o,
                                  rsp_a_to_o, rsp_b_to_o}, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_reset", req_ready_o, 1);
    checkOutput("valid_after_reset", rsp_valid_o, 0);

    $display("[TB] basic read");
    aTog = '{10};
    bTog = '{20};
    applyStimulus(3'd3, 3'd5);
    checkOutput("basic_rsp_a", rsp_a_o, 12);
    checkOutput("basic_rsp_b", rsp_b_o, 22);
    checkOutput("basic_to_a", rsp_a_to_o, 0);
    checkOutput("basic_to_b", rsp_b_to_o, 0);
    checkOutput("basic_rsp_cycle", rspCyc, 23);
    handshake();
    waitIdle(gapLen);

    $display("[TB] simultaneous edges with backpressure");
    aTog = '{7};
    bTog = '{7};
    applyStimulus(3'd1, 3'd2);
    checkOutput("simul_rsp_a", rsp_a_o, 9);
    checkOutput("simul_rsp_b", rsp_b_o, 9);
    checkOutput("simul_rsp_cycle", rspCyc, 10);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid_o !== 1'b1 || rsp_a_o !== 8'd9 || rsp_b_o !== 8'd9 || req_ready_o !== 1'b0) bad++;
      a_i = i[0];
      b_i = i[1];
      tick();
    end
    checkOutput("bp_stable", bad, 0);
    checkOutput("bp_rsp_a_after", rsp_a_o, 9);
    handshake();
    waitIdle(gapLen);
    checkOutput("gap_len", gapLen, 5);

    $display("[TB] stale level and second pulse");
    a_i = 1'b1;
    repeat (4) tick();
    aTog = '{3, 15, 20, 30, 33};
    bTog = '{40};
    applyStimulus(3'd7, 3'd0);
    checkOutput("stale_rsp_a", rsp_a_o, 17);
    checkOutput("stale_rsp_b", rsp_b_o, 42);
    checkOutput("stale_to_a", rsp_a_to_o, 0);
    checkOutput("stale_rsp_cycle", rspCyc, 43);
    handshake();
    waitIdle(gapLen);

    $display("[TB] timeout on B");
    aTog = '{5};
    applyStimulus(3'd4, 3'd6);
    checkOutput("to_rsp_a", rsp_a_o, 7);
    checkOutput("to_rsp_b", rsp_b_o, 200);
    checkOutput("to_flag_a", rsp_a_to_o, 0);
    checkOutput("to_flag_b", rsp_b_to_o, 1);
    checkOutput("to_rsp_cycle", rspCyc, 201);
    handshake();
    waitIdle(gapLen);

    $display("[TB] edge in the final measure cycle");
    aTog = '{0};
    bTog = '{198};
    applyStimulus(3'd2, 3'd3);
    checkOutput("last_rsp_a", rsp_a_o, 2);
    checkOutput("last_rsp_b", rsp_b_o, 200);
    checkOutput("last_flag_b", rsp_b_to_o, 0);
    checkOutput("last_rsp_cycle", rspCyc, 201);
    handshake();
    waitIdle(gapLen);

    $display("[TB] reset in the middle of a measurement");
    req_ra_i = 3'd6;
    req_rb_i = 3'd1;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    repeat (50) tick();
    checkOutput("mid_ra_o", ra_o, 6);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_outputs", {req_ready_o, re_o, ra_o, rb_o, rsp_valid_o, rsp_a_o, rsp_b_o,
                                      rsp_a_to_o, rsp_b_to_o}, 0);
    #3;
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_mid_reset", req_ready_o, 1);
    aTog = '{9};
    bTog = '{4};
    applyStimulus(3'd2, 3'd4);
    checkOutput("post_rsp_a", rsp_a_o, 11);
    checkOutput("post_rsp_b", rsp_b_o, 6);
    checkOutput("post_rsp_cycle", rspCyc, 12);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
